// File: rtl/ex_muldiv_unit_if.sv
// Handshake and result bundle between the EX stage and the iterative mul/div unit.
// The EX stage drives the master side; the unit implements the slave side.
interface ex_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             flush;
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hilo_read;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;

  modport master (
    output flush,
    output start,
    output op,
    output rs_data,
    output rt_data,
    output hilo_read,
    input  hi,
    input  lo,
    input  busy,
    input  stall,
    input  done,
    input  div_by_zero
  );

  modport slave (
    input  flush,
    input  start,
    input  op,
    input  rs_data,
    input  rt_data,
    input  hilo_read,
    output hi,
    output lo,
    output busy,
    output stall,
    output done,
    output div_by_zero
  );

endinterface

// File: rtl/ex_muldiv_unit.sv
// Execute-stage iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
// Signed ops run on magnitudes; signs are reapplied in the single FIX cycle.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  ex_muldiv_unit_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [WIDTH-1:0]    acc_hi_q;
  logic [WIDTH-1:0]    acc_lo_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    hi_q;
  logic [WIDTH-1:0]    lo_q;
  logic                is_div_q;
  logic                neg_q;
  logic                rem_neg_q;
  logic                dbz_q;
  logic                done_q;
  logic                dbz_out_q;

  // Operand magnitudes; signedness only matters for MULT/DIV (op[0] == 0).
  logic                signed_op;
  logic                rs_neg;
  logic                rt_neg;
  logic [WIDTH-1:0]    rs_mag;
  logic [WIDTH-1:0]    rt_mag;

  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      div_shift;
  logic                div_ge;
  logic [WIDTH-1:0]    div_sub;

  logic [2*WIDTH-1:0]  product;
  logic [2*WIDTH-1:0]  product_fix;
  logic [WIDTH-1:0]    quot_fix;
  logic [WIDTH-1:0]    rem_fix;

  always_comb begin
    signed_op = ~bus.op[0];
    rs_neg    = signed_op & bus.rs_data[WIDTH-1];
    rt_neg    = signed_op & bus.rt_data[WIDTH-1];
    rs_mag    = rs_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
    rt_mag    = rt_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;
  end

  // Multiply: the multiplier sits in acc_lo and is consumed LSB first while the
  // product shifts in from the top.
  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? b_q : {WIDTH{1'b0}})};
  end

  // Divide: restoring step; the dividend shifts out of acc_lo while quotient bits
  // shift in at the bottom, so acc_lo ends up holding the quotient.
  always_comb begin
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    // Only used when div_ge, where the true difference is below b_q and fits WIDTH bits.
    div_sub   = div_shift[WIDTH-1:0] - b_q;
  end

  always_comb begin
    product     = {acc_hi_q, acc_lo_q};
    product_fix = neg_q ? (~product + 1'b1) : product;
    quot_fix    = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
    rem_fix     = rem_neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      if (bus.flush) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              case (bus.op)
                OpMult, OpMultu: begin
                  acc_hi_q  <= '0;
                  acc_lo_q  <= rt_mag;
                  b_q       <= rs_mag;
                  neg_q     <= rs_neg ^ rt_neg;
                  rem_neg_q <= 1'b0;
                  is_div_q  <= 1'b0;
                  dbz_q     <= 1'b0;
                  cnt_q     <= CntW'(WIDTH - 1);
                  state_q   <= StRun;
                end
                OpDiv, OpDivu: begin
                  is_div_q <= 1'b1;
                  if (bus.rt_data == '0) begin
                    // Raw dividend is parked in acc_hi so FIX can return it in HI.
                    acc_hi_q <= bus.rs_data;
                    dbz_q    <= 1'b1;
                    state_q  <= StFix;
                  end else begin
                    acc_hi_q  <= '0;
                    acc_lo_q  <= rs_mag;
                    b_q       <= rt_mag;
                    neg_q     <= rs_neg ^ rt_neg;
                    rem_neg_q <= rs_neg;
                    dbz_q     <= 1'b0;
                    cnt_q     <= CntW'(WIDTH - 1);
                    state_q   <= StRun;
                  end
                end
                OpMthi:  hi_q <= bus.rs_data;
                OpMtlo:  lo_q <= bus.rs_data;
                default: ;
              endcase
            end
          end
          StRun: begin
            if (is_div_q) begin
              acc_hi_q <= div_ge ? div_sub : div_shift[WIDTH-1:0];
              acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
            end else begin
              acc_hi_q <= mul_sum[WIDTH:1];
              acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              state_q <= StFix;
            end
          end
          StFix: begin
            if (dbz_q) begin
              hi_q <= acc_hi_q;
              lo_q <= '1;
            end else if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= product_fix[2*WIDTH-1:WIDTH];
              lo_q <= product_fix[WIDTH-1:0];
            end
            done_q    <= 1'b1;
            dbz_out_q <= dbz_q;
            state_q   <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    bus.hi          = hi_q;
    bus.lo          = lo_q;
    bus.busy        = (state_q != StIdle);
    bus.stall       = (state_q != StIdle) & (bus.start | bus.hilo_read);
    bus.done        = done_q;
    bus.div_by_zero = dbz_out_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed testbench for ex_muldiv_unit: arithmetic results, latency, stall, flush and reset.
module tb_ex_muldiv_unit;

  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ex_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  ex_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Launch an op and wait (bounded) for done; edges counts E0 inclusive.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output int busy_cycles);
    bus.op      = op;
    bus.rs_data = a;
    bus.rt_data = b;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    edges       = 1;
    busy_cycles = 0;
    while (!bus.done && edges < 200) begin
      if (bus.busy) busy_cycles++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    reset         = 1'b0;
    bus.flush     = 1'b0;
    bus.start     = 1'b0;
    bus.op        = 3'b000;
    bus.rs_data   = '0;
    bus.rt_data   = '0;
    bus.hilo_read = 1'b1;
    #12;
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", bus.hi, bus.lo);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_by_zero !== 1'b0
        || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b done=%b dbz=%b stall=%b expected 0", bus.busy,
               bus.done, bus.div_by_zero, bus.stall);
    end
    bus.hilo_read = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mthi_mtlo;
    bus.op = 3'b100; bus.rs_data = 32'hA5A5A5A5; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.hi !== 32'hA5A5A5A5 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mthi: got hi=%h busy=%b done=%b expected a5a5a5a5/0/0", bus.hi, bus.busy,
               bus.done);
    end
    bus.op = 3'b101; bus.rs_data = 32'h5A5A5A5A; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.lo !== 32'h5A5A5A5A || bus.hi !== 32'hA5A5A5A5 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: got hi=%h lo=%h busy=%b expected a5a5a5a5/5a5a5a5a/0", bus.hi, bus.lo,
               bus.busy);
    end
  endtask

  task automatic test_undefined_op;
    bus.op = 3'b110; bus.rs_data = 32'h12121212; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'hA5A5A5A5 || bus.lo !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL undefined_op: got busy=%b hi=%h lo=%h expected 0/a5a5a5a5/5a5a5a5a",
               bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_mult;
    int e, bc;
    run_op(3'b000, 32'hFFFFFFFD, 32'd7, e, bc);
    checks++;
    if (e !== 34 || bc !== 33) begin
      errors++;
      $display("FAIL mult_latency: got edges=%0d busy=%0d expected 34/33", e, bc);
    end
    checks++;
    if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFEB || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL mult_result: got hi=%h lo=%h dbz=%b expected ffffffff/ffffffeb/0", bus.hi,
               bus.lo, bus.div_by_zero);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mult_done_busy: got busy=%b expected 0", bus.busy);
    end
    // Back-to-back: new op launched from the done cycle.
    run_op(3'b000, 32'h80000000, 32'h80000000, e, bc);
    checks++;
    if (e !== 34 || bus.hi !== 32'h40000000 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL mult_minmin: got edges=%0d hi=%h lo=%h expected 34/40000000/0", e, bus.hi,
               bus.lo);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got done=%b expected 0", bus.done);
    end
  endtask

  task automatic test_multu;
    int e, bc;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, e, bc);
    checks++;
    if (e !== 34 || bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001) begin
      errors++;
      $display("FAIL multu: got edges=%0d hi=%h lo=%h expected 34/fffffffe/00000001", e, bus.hi,
               bus.lo);
    end
  endtask

  task automatic test_div;
    int e, bc;
    run_op(3'b011, 32'd100, 32'd7, e, bc);
    checks++;
    if (e !== 34 || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      errors++;
      $display("FAIL divu: got edges=%0d lo=%h hi=%h expected 34/e/2", e, bus.lo, bus.hi);
    end
    run_op(3'b010, 32'hFFFFFFF9, 32'd2, e, bc);
    checks++;
    if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF || bus.div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL div_neg: got lo=%h hi=%h dbz=%b expected fffffffd/ffffffff/0", bus.lo,
               bus.hi, bus.div_by_zero);
    end
    run_op(3'b010, 32'd7, 32'hFFFFFFFE, e, bc);
    checks++;
    if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'd1) begin
      errors++;
      $display("FAIL div_negdivisor: got lo=%h hi=%h expected fffffffd/1", bus.lo, bus.hi);
    end
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, e, bc);
    checks++;
    if (bus.lo !== 32'h80000000 || bus.hi !== 32'h0) begin
      errors++;
      $display("FAIL div_overflow: got lo=%h hi=%h expected 80000000/0", bus.lo, bus.hi);
    end
  endtask

  task automatic test_div_zero;
    int e, bc;
    run_op(3'b010, 32'h12345678, 32'h0, e, bc);
    checks++;
    if (e !== 2 || bc !== 1) begin
      errors++;
      $display("FAIL dbz_latency: got edges=%0d busy=%0d expected 2/1", e, bc);
    end
    checks++;
    if (bus.hi !== 32'h12345678 || bus.lo !== 32'hFFFFFFFF || bus.div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_result: got hi=%h lo=%h dbz=%b expected 12345678/ffffffff/1", bus.hi,
               bus.lo, bus.div_by_zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.div_by_zero !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL dbz_clear: got dbz=%b done=%b expected 0/0", bus.div_by_zero, bus.done);
    end
  endtask

  task automatic test_stall;
    int cyc = 0;
    int bad = 0;
    bus.op = 3'b001; bus.rs_data = 32'd3; bus.rt_data = 32'd5; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.hilo_read = 1'b1;
    while (bus.busy && cyc < 100) begin
      if (bus.stall !== 1'b1) bad++;
      // A start while busy must be held off and not accepted.
      if (cyc == 3) begin
        bus.op = 3'b100; bus.rs_data = 32'hDEADBEEF; bus.start = 1'b1;
      end
      if (cyc == 8) bus.start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (bad !== 0 || cyc !== 33) begin
      errors++;
      $display("FAIL stall_busy: got %0d non-stall cycles over %0d busy expected 0/33", bad, cyc);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: got done=%b stall=%b expected 1/0", bus.done, bus.stall);
    end
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'd15) begin
      errors++;
      $display("FAIL stall_result: got hi=%h lo=%h expected 0/f", bus.hi, bus.lo);
    end
    bus.hilo_read = 1'b0;
  endtask

  task automatic test_flush;
    int dones = 0;
    bus.op = 3'b001; bus.rs_data = 32'h10000; bus.rt_data = 32'h10000; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'd15) begin
      errors++;
      $display("FAIL flush_run: got busy=%b hi=%h lo=%h expected 0/0/f", bus.busy, bus.hi,
               bus.lo);
    end
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    checks++;
    if (dones !== 0 || bus.hi !== 32'h0 || bus.lo !== 32'd15) begin
      errors++;
      $display("FAIL flush_nodone: got dones=%0d hi=%h lo=%h expected 0/0/f", dones, bus.hi,
               bus.lo);
    end
    bus.op = 3'b000; bus.rs_data = 32'd9; bus.rt_data = 32'd9;
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start_mult: got busy=%b expected 0", bus.busy);
    end
    bus.op = 3'b100; bus.rs_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    checks++;
    if (bus.hi !== 32'h0) begin
      errors++;
      $display("FAIL flush_start_mthi: got hi=%h expected 0", bus.hi);
    end
  endtask

  task automatic test_reset_mid;
    bus.op = 3'b100; bus.rs_data = 32'h11111111; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.op = 3'b011; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.hi !== 32'h11111111) begin
      errors++;
      $display("FAIL pre_reset: got busy=%b hi=%h expected 1/11111111", bus.busy, bus.hi);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got hi=%h lo=%h busy=%b done=%b expected 0/0/0/0", bus.hi,
               bus.lo, bus.busy, bus.done);
    end
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b expected 0", bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_undefined_op();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
